// File: rtl/lc3b_types.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lc3b_types : shared LC-3b word type and branch history table types  |
// | Rev 1.0    : initial BHT typedefs                                    |
// +----------------------------------------------------------------------+
package lc3b_types;

    typedef logic [15:0] lc3b_word;

    localparam int c_bht_index_bits = 4;
    localparam int c_bht_tag_bits   = 15 - c_bht_index_bits;

    typedef logic [c_bht_index_bits-1:0] lc3b_bht_index;
    typedef logic [c_bht_tag_bits-1:0]   lc3b_bht_tag;
    typedef logic [1:0]                  lc3b_bht_ctr;

    localparam lc3b_bht_ctr c_ctr_init  = 2'b01;
    localparam lc3b_bht_ctr c_ctr_alloc = 2'b10;

endpackage
`default_nettype wire

// File: rtl/branch_history_table_sat_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bht_sat_counter : 2-bit saturating up/down counter with load         |
// | Rev 1.0         : initial release                                    |
// +----------------------------------------------------------------------+
module bht_sat_counter
    import lc3b_types::*;
(
    input  lc3b_bht_ctr ctr_in,
    input  logic        inc,
    input  logic        dec,
    input  logic        load,
    input  lc3b_bht_ctr load_val,
    output lc3b_bht_ctr ctr_out
);

    always_comb begin
        ctr_out = ctr_in;
        if (load) begin
            ctr_out = load_val;
        end else if (inc) begin
            if (ctr_in != 2'b11) ctr_out = ctr_in + 2'b01;
        end else if (dec) begin
            if (ctr_in != 2'b00) ctr_out = ctr_in - 2'b01;
        end
    end

endmodule
`default_nettype wire

// File: rtl/branch_history_table.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | branch_history_table : IF-stage direct-mapped branch predictor with  |
// | MEM-stage update and registered mispredict/redirect. Optional        |
// | statistics counters are enabled with the BHT_STATS_EN macro.         |
// | Rev 1.0              : initial release                               |
// +----------------------------------------------------------------------+
module branch_history_table
    import lc3b_types::*;
#(
    parameter int          INDEX_BITS = c_bht_index_bits,
    parameter lc3b_bht_ctr CTR_INIT   = c_ctr_init
)(
    input  logic     clk,
    input  logic     reset,
    input  logic     stall,
    input  lc3b_word fetch_pc,
    output logic     predict_taken,
    output lc3b_word predict_target,
    input  logic     resolve_valid,
    input  lc3b_word resolve_pc,
    input  logic     resolve_taken,
    input  lc3b_word resolve_target,
    input  logic     resolve_pred_taken,
    input  lc3b_word resolve_pred_target,
    output logic     mispredict,
    output lc3b_word redirect_pc
`ifdef BHT_STATS_EN
    ,
    output logic [15:0] stat_branches,
    output logic [15:0] stat_mispredicts
`endif
);

    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam int TAG_W   = 15 - INDEX_BITS;

    logic              r_valid  [ENTRIES];
    logic [TAG_W-1:0]  r_tag    [ENTRIES];
    lc3b_word          r_target [ENTRIES];
    lc3b_bht_ctr       r_ctr    [ENTRIES];

    logic              r_mispredict;
    lc3b_word          r_redirect_pc;

    // Fetch-side lookup: purely combinational, no bypass from the update port
    logic [INDEX_BITS-1:0] w_fidx;
    logic [TAG_W-1:0]      w_ftag;
    logic                  w_fhit;

    assign w_fidx = fetch_pc[INDEX_BITS:1];
    assign w_ftag = fetch_pc[15:INDEX_BITS+1];
    assign w_fhit = r_valid[w_fidx] && (r_tag[w_fidx] == w_ftag);

    assign predict_taken  = w_fhit && r_ctr[w_fidx][1];
    assign predict_target = w_fhit ? r_target[w_fidx] : fetch_pc + 16'd2;

    logic [INDEX_BITS-1:0] w_ridx;
    logic [TAG_W-1:0]      w_rtag;
    logic                  w_rhit;
    logic                  w_upd;
    logic                  w_replace;
    logic                  w_mis_cond;
    lc3b_bht_ctr           w_ctr_next;

    assign w_ridx    = resolve_pc[INDEX_BITS:1];
    assign w_rtag    = resolve_pc[15:INDEX_BITS+1];
    assign w_rhit    = r_valid[w_ridx] && (r_tag[w_ridx] == w_rtag);
    assign w_upd     = resolve_valid && !stall;
    // A taken branch evicting a different valid branch starts weakly taken
    assign w_replace = resolve_taken && r_valid[w_ridx] && !w_rhit;

    assign w_mis_cond = w_upd &&
                        ((resolve_taken != resolve_pred_taken) ||
                         (resolve_taken && (resolve_target != resolve_pred_target)));

    bht_sat_counter u_ctr (
        .ctr_in   (r_ctr[w_ridx]),
        .inc      (resolve_taken && !w_replace),
        .dec      (!resolve_taken && w_rhit),
        .load     (w_replace),
        .load_val (c_ctr_alloc),
        .ctr_out  (w_ctr_next)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_ctr[i]    <= CTR_INIT;
            end
        end else if (w_upd) begin
            if (resolve_taken) begin
                r_valid[w_ridx]  <= 1'b1;
                r_tag[w_ridx]    <= w_rtag;
                r_target[w_ridx] <= resolve_target;
                r_ctr[w_ridx]    <= w_ctr_next;
            end else if (w_rhit) begin
                r_ctr[w_ridx]    <= w_ctr_next;
            end
        end
    end

    // Stall freezes the pulse so the flush sequencer sees it once unstalled
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mispredict  <= 1'b0;
            r_redirect_pc <= 16'h0000;
        end else if (!stall) begin
            r_mispredict <= w_mis_cond;
            if (w_mis_cond) begin
                r_redirect_pc <= resolve_taken ? resolve_target : resolve_pc + 16'd2;
            end
        end
    end

    assign mispredict  = r_mispredict;
    assign redirect_pc = r_redirect_pc;

`ifdef BHT_STATS_EN
    logic [15:0] r_stat_branches;
    logic [15:0] r_stat_mispredicts;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stat_branches    <= 16'h0000;
            r_stat_mispredicts <= 16'h0000;
        end else begin
            if (w_upd && (r_stat_branches != 16'hFFFF)) begin
                r_stat_branches <= r_stat_branches + 16'd1;
            end
            if (w_mis_cond && (r_stat_mispredicts != 16'hFFFF)) begin
                r_stat_mispredicts <= r_stat_mispredicts + 16'd1;
            end
        end
    end

    assign stat_branches    = r_stat_branches;
    assign stat_mispredicts = r_stat_mispredicts;
`endif

endmodule
`default_nettype wire

// File: tb/tb_branch_history_table.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_branch_history_table : directed self-checking bench for the BHT   |
// | Rev 1.0                 : initial release                            |
// +----------------------------------------------------------------------+
module tb_branch_history_table;

    logic        clk;
    logic        reset;
    logic        stall;
    logic [15:0] fetch_pc;
    logic        predict_taken;
    logic [15:0] predict_target;
    logic        resolve_valid;
    logic [15:0] resolve_pc;
    logic        resolve_taken;
    logic [15:0] resolve_target;
    logic        resolve_pred_taken;
    logic [15:0] resolve_pred_target;
    logic        mispredict;
    logic [15:0] redirect_pc;
`ifdef BHT_STATS_EN
    logic [15:0] stat_branches;
    logic [15:0] stat_mispredicts;
`endif

    int n_checks;
    int n_errors;

    branch_history_table dut (
        .clk                 (clk),
        .reset               (reset),
        .stall               (stall),
        .fetch_pc            (fetch_pc),
        .predict_taken       (predict_taken),
        .predict_target      (predict_target),
        .resolve_valid       (resolve_valid),
        .resolve_pc          (resolve_pc),
        .resolve_taken       (resolve_taken),
        .resolve_target      (resolve_target),
        .resolve_pred_taken  (resolve_pred_taken),
        .resolve_pred_target (resolve_pred_target),
        .mispredict          (mispredict),
        .redirect_pc         (redirect_pc)
`ifdef BHT_STATS_EN
        ,
        .stat_branches       (stat_branches),
        .stat_mispredicts    (stat_mispredicts)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic look(input string tag, input logic [15:0] pc,
                        input logic exp_taken, input logic [15:0] exp_target);
        fetch_pc = pc;
        #1;
        chk({tag, "_taken"}, {15'd0, predict_taken}, {15'd0, exp_taken});
        chk({tag, "_target"}, predict_target, exp_target);
    endtask

    task automatic resolve(input logic [15:0] pc, input logic taken, input logic [15:0] tgt,
                           input logic ptaken, input logic [15:0] ptgt);
        resolve_valid       = 1'b1;
        resolve_pc          = pc;
        resolve_taken       = taken;
        resolve_target      = tgt;
        resolve_pred_taken  = ptaken;
        resolve_pred_target = ptgt;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset = 1'b1;
        stall = 1'b0;
        fetch_pc = 16'h0000;
        resolve_valid = 1'b0;
        resolve_pc = 16'h0000;
        resolve_taken = 1'b0;
        resolve_target = 16'h0000;
        resolve_pred_taken = 1'b0;
        resolve_pred_target = 16'h0000;
        tick();
        tick();
        reset = 1'b0;

        // Reset state and first lookup miss
        chk("rst_mispredict", {15'd0, mispredict}, 16'd0);
        chk("rst_redirect", redirect_pc, 16'h0000);
        look("rst_fetch", 16'h3000, 1'b0, 16'h3002);

        // First taken resolve allocates with ctr 10 and mispredicts
        resolve(16'h3000, 1'b1, 16'h3010, 1'b0, 16'h0000);
        tick();
        resolve_valid = 1'b0;
        chk("alloc_mispredict", {15'd0, mispredict}, 16'd1);
        chk("alloc_redirect", redirect_pc, 16'h3010);
        look("alloc_fetch", 16'h3000, 1'b1, 16'h3010);
        tick();
        chk("alloc_pulse_end", {15'd0, mispredict}, 16'd0);

        // Three correctly predicted taken resolves saturate the counter
        for (int i = 0; i < 3; i++) begin
            resolve(16'h3000, 1'b1, 16'h3010, 1'b1, 16'h3010);
            tick();
            chk("sat_no_mispredict", {15'd0, mispredict}, 16'd0);
        end

        // Not-taken from 11 -> 10, still predicts taken
        resolve(16'h3000, 1'b0, 16'h3010, 1'b1, 16'h3010);
        tick();
        chk("nt1_mispredict", {15'd0, mispredict}, 16'd1);
        chk("nt1_redirect", redirect_pc, 16'h3002);
        look("nt1_fetch", 16'h3000, 1'b1, 16'h3010);
        // Back-to-back second not-taken: 10 -> 01, hit keeps stored target
        tick();
        resolve_valid = 1'b0;
        chk("nt2_mispredict", {15'd0, mispredict}, 16'd1);
        chk("nt2_redirect", redirect_pc, 16'h3002);
        look("nt2_fetch", 16'h3000, 1'b0, 16'h3010);

        // Aliasing: 0x5000 shares the index of 0x3000 and replaces it
        resolve(16'h5000, 1'b1, 16'h5020, 1'b0, 16'h0000);
        tick();
        chk("alias_redirect", redirect_pc, 16'h5020);
        // Not-taken at the evicted tag must not touch the entry
        resolve(16'h3000, 1'b0, 16'h0000, 1'b0, 16'h0000);
        tick();
        resolve_valid = 1'b0;
        chk("alias_nt_no_mispredict", {15'd0, mispredict}, 16'd0);
        look("alias_old", 16'h3000, 1'b0, 16'h3002);
        look("alias_new", 16'h5000, 1'b1, 16'h5020);

        // Stalled resolve has no effect
        stall = 1'b1;
        resolve(16'h4002, 1'b1, 16'h4100, 1'b0, 16'h0000);
        tick();
        stall = 1'b0;
        resolve_valid = 1'b0;
        chk("stall_no_mispredict", {15'd0, mispredict}, 16'd0);
        look("stall_no_update", 16'h4002, 1'b0, 16'h4004);

        // Pending pulse held across a stall, cleared by the first free edge
        resolve(16'h4002, 1'b1, 16'h4100, 1'b0, 16'h0000);
        tick();
        resolve_valid = 1'b0;
        stall = 1'b1;
        chk("hold_pulse0", {15'd0, mispredict}, 16'd1);
        tick();
        chk("hold_pulse1", {15'd0, mispredict}, 16'd1);
        tick();
        chk("hold_pulse2", {15'd0, mispredict}, 16'd1);
        chk("hold_redirect", redirect_pc, 16'h4100);
        stall = 1'b0;
        tick();
        chk("hold_cleared", {15'd0, mispredict}, 16'd0);
        chk("hold_redirect_keep", redirect_pc, 16'h4100);
        look("hold_fetch", 16'h4002, 1'b1, 16'h4100);

`ifdef BHT_STATS_EN
        chk("stat_branches", stat_branches, 16'd9);
        chk("stat_mispredicts", stat_mispredicts, 16'd5);
`endif

        // Fall-through wraps at the top of memory
        look("wrap", 16'hFFFE, 1'b0, 16'h0000);

        // Reset wins over a simultaneous taken resolve
        reset = 1'b1;
        resolve(16'h6004, 1'b1, 16'h6100, 1'b0, 16'h0000);
        tick();
        reset = 1'b0;
        resolve_valid = 1'b0;
        chk("rst2_mispredict", {15'd0, mispredict}, 16'd0);
        chk("rst2_redirect", redirect_pc, 16'h0000);
        look("rst2_new", 16'h6004, 1'b0, 16'h6006);
        look("rst2_old", 16'h5000, 1'b0, 16'h5002);
        look("rst2_old2", 16'h4002, 1'b0, 16'h4004);
`ifdef BHT_STATS_EN
        chk("rst2_stat_branches", stat_branches, 16'd0);
        chk("rst2_stat_mispredicts", stat_mispredicts, 16'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
